// File: rtl/slave_mem_port.sv
// Bit-serial slave that turns read/write command frames into single memory accesses and
// streams read data back MSB first. Define SLAVE_PARITY_EN to add even parity on data.
module slave_mem_port #(
    parameter int unsigned MEMORY_DEPTH = 4092,
    parameter int unsigned DATA_WIDTH   = 16,
    localparam int unsigned ADDR_WIDTH  = $clog2(MEMORY_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_in,
    input  logic                  s_valid,
    output logic                  s_out,
    output logic                  s_out_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int unsigned MaxWidth = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    // One spare count so SEND can reach DATA_WIDTH when a parity bit is appended
    localparam int unsigned CntWidth = $clog2(MaxWidth + 1);
    localparam logic [CntWidth-1:0] AddrLast = CntWidth'(ADDR_WIDTH - 1);
    localparam logic [CntWidth-1:0] DataLast = CntWidth'(DATA_WIDTH - 1);
`ifdef SLAVE_PARITY_EN
    localparam logic [CntWidth-1:0] SendLast = CntWidth'(DATA_WIDTH);
`else
    localparam logic [CntWidth-1:0] SendLast = CntWidth'(DATA_WIDTH - 1);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StWrite,
        StReadAddr,
        StReadCap,
        StSend
`ifdef SLAVE_PARITY_EN
        ,
        StParity
`endif
    } state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
`ifdef SLAVE_PARITY_EN
    logic                  par_q, par_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = 1'b0;
`ifdef SLAVE_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            StIdle: begin
                if (s_valid) begin
                    cmd_d   = s_in;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (!s_valid) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    addr_d = {addr_q[ADDR_WIDTH-2:0], s_in};
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == AddrLast) state_d = cmd_q ? StData : StReadAddr;
                end
            end
            StData: begin
                if (!s_valid) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    data_d = {data_q[DATA_WIDTH-2:0], s_in};
                    cnt_d  = cnt_q + 1'b1;
`ifdef SLAVE_PARITY_EN
                    if (cnt_q == DataLast) state_d = StParity;
`else
                    if (cnt_q == DataLast) state_d = StWrite;
`endif
                end
            end
`ifdef SLAVE_PARITY_EN
            StParity: begin
                // Even parity: the received bit must make the total count of ones even
                if (!s_valid || (s_in != ^data_q)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StWrite;
                end
            end
`endif
            StWrite:    state_d = StIdle;
            StReadAddr: state_d = StReadCap;
            StReadCap: begin
                data_d  = mem_q;
`ifdef SLAVE_PARITY_EN
                par_d   = ^mem_q;
`endif
                state_d = StSend;
            end
            StSend: begin
                data_d = {data_q[DATA_WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == SendLast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef SLAVE_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
`ifdef SLAVE_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    logic send_bit;
`ifdef SLAVE_PARITY_EN
    assign send_bit = (cnt_q == SendLast) ? par_q : data_q[DATA_WIDTH-1];
`else
    assign send_bit = data_q[DATA_WIDTH-1];
`endif

    assign busy        = (state_q != StIdle);
    assign mem_wr      = (state_q == StWrite);
    assign s_out_valid = (state_q == StSend);
    assign s_out       = s_out_valid & send_bit;
    assign done        = mem_wr | (s_out_valid && (cnt_q == SendLast));
    assign err         = err_q;
    assign mem_addr    = addr_q;
    assign mem_data    = data_q;

endmodule

// File: doc/slave_mem_port.md
SLAVE_MEM_PORT -- requirements
Module: slave_mem_port

Interface
REQ-001 The module SHALL take parameter MEMORY_DEPTH, default 4092, the number of words in the attached memory.
REQ-002 The module SHALL take parameter DATA_WIDTH, default 16, the memory word width.
REQ-003 The module SHALL derive localparam ADDR_WIDTH = $clog2(MEMORY_DEPTH), which is 12 by default.
REQ-004 clk  input  1  the single clock; all logic is clocked on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 s_in  input  1  serial command bit, sampled only when s_valid=1.
REQ-007 s_valid  input  1  marks a valid frame bit; it stays high for every bit of a frame without gaps.
REQ-008 s_out  output  1  serial read-data bit, MSB first.
REQ-009 s_out_valid  output  1  qualifies s_out.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when a transaction completes.
REQ-012 err  output  1  one-cycle pulse when a frame is aborted or fails parity.
REQ-013 mem_wr  output  1  memory write strobe.
REQ-014 mem_addr  output  ADDR_WIDTH  memory address, driven from the internal address register.
REQ-015 mem_data  output  DATA_WIDTH  memory write data, driven from the internal data register.
REQ-016 mem_q  input  DATA_WIDTH  memory read data, valid one cycle after the memory registers mem_addr while mem_wr=0.

Function
REQ-017 The frame format SHALL be: 1 command bit (1 = write, 0 = read), then ADDR_WIDTH address bits MSB first, then, for writes only, DATA_WIDTH data bits MSB first.
REQ-018 The state machine SHALL have the states IDLE, ADDR, DATA, WRITE, READ_ADDR, READ_CAP, SEND, with PARITY added when the configuration macro is defined.
REQ-019 In IDLE, a cycle with s_valid=1 SHALL latch the command bit and move to ADDR.
REQ-020 ADDR SHALL shift in ADDR_WIDTH bits, then go to DATA for a write or to READ_ADDR for a read.
REQ-021 DATA SHALL shift in DATA_WIDTH bits, then go to WRITE.
REQ-022 WRITE SHALL assert mem_wr for exactly one cycle, with mem_addr and mem_data stable, pulse done in that same cycle, and return to IDLE.
REQ-023 READ_ADDR SHALL hold mem_wr=0 and mem_addr stable for one cycle, then go to READ_CAP.
REQ-024 READ_CAP SHALL capture mem_q into the shift register at the end of the cycle, then go to SEND.
REQ-025 SEND SHALL drive s_out_valid=1 for DATA_WIDTH consecutive cycles, MSB first, pulse done on the last bit, and return to IDLE.
REQ-026 The first s_out bit SHALL appear in the 3rd cycle after the edge that samples the last address bit.
REQ-027 If s_valid falls before a frame is complete, the block SHALL pulse err, perform no memory access, and return to IDLE on the next cycle.
REQ-028 s_valid SHALL be ignored in WRITE, READ_ADDR, READ_CAP and SEND, and those bits SHALL NOT start a new frame.
REQ-029 A new frame MAY start in the cycle immediately after the block returns to IDLE.
REQ-030 Bit counters SHALL be sized for max(ADDR_WIDTH, DATA_WIDTH) and SHALL reset to 0 on every state entry.
REQ-031 An address at or above MEMORY_DEPTH SHALL be passed through unchanged; bounds checking is the host's responsibility.
REQ-032 mem_wr SHALL be 0 in every state except WRITE.

Reset
REQ-033 When rst=1 at a rising edge, the state SHALL become IDLE and counters SHALL clear.
REQ-034 When rst=1 at a rising edge, s_out, s_out_valid, busy, done, err and mem_wr SHALL become 0, and mem_addr and mem_data SHALL clear to 0.
REQ-035 A reset during any state, including WRITE, SHALL deassert mem_wr by the next edge and abandon the frame without an err pulse.

Configuration
REQ-036 When SLAVE_PARITY_EN is defined, a write frame SHALL carry one extra trailing even-parity bit over the data, checked in the PARITY state.
REQ-037 With SLAVE_PARITY_EN defined, a parity mismatch SHALL pulse err, suppress WRITE, and return the block to IDLE.
REQ-038 With SLAVE_PARITY_EN defined, a read response SHALL append one even-parity bit, so SEND lasts DATA_WIDTH+1 cycles and done pulses on the parity bit.
REQ-039 When SLAVE_PARITY_EN is not defined, no parity bits SHALL exist and err SHALL pulse only for aborted frames.

Verification
REQ-040 Reset: hold rst=1 for 2 cycles mid-frame -> all outputs are 0, busy=0, and no mem_wr.
REQ-041 Write: frame 1, address 0x123, data 0xBEEF -> one mem_wr cycle with mem_addr=0x123 and mem_data=0xBEEF, and done in the same cycle.
REQ-042 Read: with the memory model holding 0xBEEF at 0x123, frame 0 then 0x123 -> first s_out bit 3 cycles after the last address bit, then 16 bits 1011111011101111, with done on the last bit.
REQ-043 Abort: drop s_valid after 5 address bits -> err pulses once, no mem_wr, and a following full write frame succeeds.
REQ-044 Back-to-back: a write frame, then a read frame starting the cycle after done -> the read returns the just-written value.
REQ-045 With SLAVE_PARITY_EN defined: write 0x0001 with parity bit 0 -> err pulses and no mem_wr; the same frame with parity bit 1 -> the write occurs.
